// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive bus arbiter with one outstanding split transaction.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ID_WIDTH       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   split_in,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [ID_WIDTH-1:0]    owner_id,
  output logic                   bus_busy,
  output logic                   split_pending,
  output logic [ID_WIDTH-1:0]    split_id,
  output logic                   split_err,
  output logic                   timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] bgrant_q;
  logic [ID_WIDTH-1:0]    owner_q;
  logic [ID_WIDTH-1:0]    rr_q;
  logic [ID_WIDTH-1:0]    split_id_q;
  logic                   split_pending_q;
  logic                   split_err_q;
  logic                   split_in_q;

  logic [NUM_MASTERS-1:0] split_mask_d;
  logic [NUM_MASTERS-1:0] elig_d;
  logic [ID_WIDTH-1:0]    pick_d;
  logic                   pick_vld_d;
  logic                   split_rise;

  assign split_rise   = split_in & ~split_in_q;
  assign split_mask_d = split_pending_q ? (NUM_MASTERS'(1) << split_id_q) : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_MASTERS-1:0] to_mask_q;
  logic                   timeout_q;

  assign elig_d  = breq & ~split_mask_d & ~to_mask_q;
  assign timeout = timeout_q;
`else
  assign elig_d  = breq & ~split_mask_d;
  assign timeout = 1'b0;
`endif

  // First eligible master searching upward from rr_q+1, wrapping.
  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] idx_w;
    idx        = 0;
    idx_w      = '0;
    pick_d     = '0;
    pick_vld_d = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx   = (int'(rr_q) + i) % NUM_MASTERS;
      idx_w = ID_WIDTH'(idx);
      if (!pick_vld_d && elig_d[idx_w]) begin
        pick_vld_d = 1'b1;
        pick_d     = idx_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      bgrant_q        <= '0;
      owner_q         <= '0;
      rr_q            <= ID_WIDTH'(NUM_MASTERS - 1);
      split_id_q      <= '0;
      split_pending_q <= 1'b0;
      split_err_q     <= 1'b0;
      split_in_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q           <= '0;
      to_mask_q       <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      split_in_q  <= split_in;
      split_err_q <= split_rise & split_pending_q;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      to_mask_q <= to_mask_q & breq;
`endif
      case (state_q)
        ST_IDLE: begin
          if (split_pending_q && !split_in) begin
            bgrant_q        <= NUM_MASTERS'(1) << split_id_q;
            owner_q         <= split_id_q;
            split_pending_q <= 1'b0;
            state_q         <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_q           <= '0;
`endif
          end else if (pick_vld_d) begin
            bgrant_q <= NUM_MASTERS'(1) << pick_d;
            owner_q  <= pick_d;
            rr_q     <= pick_d;
            state_q  <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // A split rise wins over a simultaneous request drop.
          if (split_rise && !split_pending_q) begin
            split_pending_q <= 1'b1;
            split_id_q      <= owner_q;
            bgrant_q        <= '0;
            owner_q         <= '0;
            state_q         <= ST_RELEASE;
          end else if (!breq[owner_q]) begin
            bgrant_q <= '0;
            owner_q  <= '0;
            state_q  <= ST_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q          <= 1'b1;
            to_mask_q[owner_q] <= 1'b1;
            bgrant_q           <= '0;
            owner_q            <= '0;
            state_q            <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign bgrant        = bgrant_q;
  assign owner_id      = owner_q;
  assign bus_busy      = |bgrant_q;
  assign split_pending = split_pending_q;
  assign split_id      = split_id_q;
  assign split_err     = split_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected output changes,
// a negedge monitor pops and compares each observed change.
module tb_bus_arbiter;
  localparam int NM  = 2;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  breq;
  logic           split_in;
  logic [NM-1:0]  bgrant;
  logic [IDW-1:0] owner_id;
  logic           bus_busy;
  logic           split_pending;
  logic [IDW-1:0] split_id;
  logic           split_err;
  logic           timeout;

  bus_arbiter #(.NUM_MASTERS(NM), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .breq(breq), .split_in(split_in),
    .bgrant(bgrant), .owner_id(owner_id), .bus_busy(bus_busy),
    .split_pending(split_pending), .split_id(split_id),
    .split_err(split_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev = '0;

  // {bgrant, owner_id, bus_busy, split_pending, split_id, split_err, timeout}
  function automatic logic [7:0] v(logic [1:0] g, logic oid, logic sp, logic sid,
                                   logic se, logic to);
    return {g, oid, |g, sp, sid, se, to};
  endfunction

  function automatic logic [7:0] obs();
    return {bgrant, owner_id, bus_busy, split_pending, split_id, split_err, timeout};
  endfunction

  task automatic push(int d, logic [7:0] val);
    exp_t e;
    e.cyc = cyc + d;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial forever begin
    logic [7:0] cur;
    exp_t       e;
    @(negedge clk);
    cur = obs();
    checks++;
    if (!$onehot0(bgrant)) begin
      errors++;
      $display("FAIL onehot cyc=%0d bgrant=%b", cyc, bgrant);
    end
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          errors++;
          $display("FAIL sb_event cyc=%0d got=%b want=%b at cyc %0d", cyc, cur, e.val, e.cyc);
        end
      end
      prev = cur;
    end
  end

  localparam logic [7:0] Z = 8'b0;
  logic [1:0] gseq [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic       oseq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0; breq = '0; split_in = 1'b0;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("reset_state", obs(), Z);
    step(2);

    // single request, grant and release
    breq = 2'b01; push(1, v(2'b01, 0, 0, 0, 0, 0));
    step(5);
    breq = 2'b00; push(1, Z);
    step(4);

    // both requesting: alternation with 2-cycle gap
    breq = 2'b11; push(1, v(gseq[0], oseq[0], 0, 0, 0, 0));
    step(1);
    for (int k = 0; k < 4; k++) begin
      step(4);
      breq = (k == 3) ? 2'b00 : (2'b11 & ~gseq[k]);
      push(1, Z);
      step(1);
      if (k < 3) begin
        breq = 2'b11;
        push(2, v(gseq[k+1], oseq[k+1], 0, 0, 0, 0));
        step(2);
      end else begin
        step(2);
      end
    end
    step(2);

    // split on master 0, master 1 served, split_err, split return
    breq = 2'b01; push(1, v(2'b01, 0, 0, 0, 0, 0));
    step(2);
    split_in = 1'b1; breq = 2'b11;
    push(1, v(2'b00, 0, 1, 0, 0, 0));
    push(3, v(2'b10, 1, 1, 0, 0, 0));
    step(3);
    split_in = 1'b0;
    step(1);
    split_in = 1'b1;
    push(1, v(2'b10, 1, 1, 0, 1, 0));
    push(2, v(2'b10, 1, 1, 0, 0, 0));
    step(2);
    split_in = 1'b0;
    step(1);
    breq = 2'b01; push(1, v(2'b00, 0, 1, 0, 0, 0));
    step(1);
    breq = 2'b11; push(2, v(2'b01, 0, 0, 0, 0, 0));
    step(2);

    // new split, master 1 granted, then async reset mid-grant
    split_in = 1'b1;
    push(1, v(2'b00, 0, 1, 0, 0, 0));
    push(3, v(2'b10, 1, 1, 0, 0, 0));
    step(4);
    push(0, Z);
    #2 rst = 1'b1;
    #1 chk("async_rst", obs(), Z);
    split_in = 1'b0;
    step(2);
    rst = 1'b0;
    push(1, v(2'b01, 0, 0, 0, 0, 0));
    step(3);
    breq = 2'b10; push(1, Z);
    step(1);
    push(2, v(2'b10, 1, 0, 0, 0, 0));
    step(4);
    breq = 2'b00; push(1, Z);
    step(3);

    // master 1 holds its request
    breq = 2'b10;
`ifdef ARB_TIMEOUT_EN
    push(1,  v(2'b10, 1, 0, 0, 0, 0));
    push(9,  v(2'b00, 0, 0, 0, 0, 1));
    push(10, Z);
    step(15);
    breq = 2'b00;
    step(1);
    breq = 2'b10; push(1, v(2'b10, 1, 0, 0, 0, 0));
    step(3);
    breq = 2'b00; push(1, Z);
    step(4);
`else
    push(1, v(2'b10, 1, 0, 0, 0, 0));
    step(15);
    breq = 2'b00; push(1, Z);
    step(4);
`endif

    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0 pending events", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
